// File: rtl/bus_arb_pkg.sv
// Shared types for the coherence-bus request arbiter: request classes, FSM states,
// CPU id/vector types used on the bus-controller side, and request classification.
package bus_arb_pkg;

    localparam int NUM_CPUS = 2;
    localparam int CPU_ID_W = $clog2(NUM_CPUS);

    typedef enum logic [1:0] {
        REQ_R     = 2'd0,
        REQ_RX    = 2'd1,
        REQ_EVICT = 2'd2,
        REQ_INV   = 2'd3
    } bus_req_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_OFFER = 2'd1,
        ARB_BUSY  = 2'd2
    } arb_state_t;

    typedef logic [CPU_ID_W-1:0] cpuid_t;
    typedef logic [NUM_CPUS-1:0] cpus_bitvec_t;

    // Writebacks outrank everything: a dirty line must leave before it is re-fetched.
    function automatic bus_req_t classify(input logic ren, input logic wen, input logic ccw);
        if (wen)             return REQ_EVICT;
        else if (ren && ccw) return REQ_RX;
        else if (ren)        return REQ_R;
        else                 return REQ_INV;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request scanning from rr_ptr upward,
// wrapping at CPUS-1 back to 0.
module rr_picker #(
    parameter  int CPUS = 2,
    localparam int ID_W = $clog2(CPUS)
) (
    input  logic [CPUS-1:0] req,
    input  logic [ID_W-1:0] rr_ptr,
    output logic            any,
    output logic [CPUS-1:0] onehot,
    output logic [ID_W-1:0] id
);

    int idx;

    always_comb begin
        // NOTE: every output gets a default before the scan so no path leaves it unassigned (no latch).
        any    = 1'b0;
        onehot = '0;
        id     = '0;
        idx    = 0;
        for (int k = 0; k < CPUS; k++) begin
            idx = (int'(rr_ptr) + k) % CPUS;
            if (!any && req[idx]) begin
                any         = 1'b1;
                onehot[idx] = 1'b1;
                id          = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/bus_req_arbiter.sv
// Round-robin arbiter offering one L1 requester at a time to the coherence bus controller.
// Optional per-CPU performance counters are compiled in with `define BUS_ARB_PERF_EN.
module bus_req_arbiter
    import bus_arb_pkg::*;
#(
    parameter  int CPUS          = 2,
    localparam int CPU_ID_LENGTH = $clog2(CPUS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CPUS-1:0]          dREN,
    input  logic [CPUS-1:0]          dWEN,
    input  logic [CPUS-1:0]          ccwrite,
    input  logic                     gnt_accept,
    input  logic                     txn_done,
    output logic                     gnt_valid,
    output logic [CPUS-1:0]          gnt_onehot,
    output logic [CPU_ID_LENGTH-1:0] gnt_id,
    output bus_req_t                 gnt_type,
    output logic                     busy,
    output logic                     proto_err
`ifdef BUS_ARB_PERF_EN
    ,
    output logic [31:0]              perf_grants [CPUS],
    output logic [31:0]              perf_wait   [CPUS]
`endif
);

    logic [CPUS-1:0]          req;
    arb_state_t               state;
    logic [CPU_ID_LENGTH-1:0] rr_ptr;
    logic [CPU_ID_LENGTH-1:0] next_ptr;

    logic                     pick_any;
    logic [CPUS-1:0]          pick_onehot;
    logic [CPU_ID_LENGTH-1:0] pick_id;
    bus_req_t                 pick_type;

    assign req = dREN | dWEN | ccwrite;

    rr_picker #(.CPUS(CPUS)) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr),
        .any    (pick_any),
        .onehot (pick_onehot),
        .id     (pick_id)
    );

    always_comb begin
        pick_type = classify(dREN[pick_id], dWEN[pick_id], ccwrite[pick_id]);
        next_ptr  = (int'(gnt_id) == CPUS - 1) ? '0 : gnt_id + 1'b1;
    end

    always_ff @(posedge clk) begin
        // NOTE: all state here is updated with <= so every branch sees the pre-edge values.
        if (rst) begin
            state      <= ARB_IDLE;
            rr_ptr     <= '0;
            gnt_valid  <= 1'b0;
            gnt_onehot <= '0;
            gnt_id     <= '0;
            gnt_type   <= REQ_R;
            busy       <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            if ((txn_done && state != ARB_BUSY) || (gnt_accept && state != ARB_OFFER))
                proto_err <= 1'b1;

            unique case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        state      <= ARB_OFFER;
                        gnt_valid  <= 1'b1;
                        gnt_onehot <= pick_onehot;
                        gnt_id     <= pick_id;
                        gnt_type   <= pick_type;
                    end
                end
                ARB_OFFER: begin
                    // Accept beats a same-cycle withdrawal; a withdrawal leaves rr_ptr alone.
                    if (gnt_accept) begin
                        state  <= ARB_BUSY;
                        busy   <= 1'b1;
                        rr_ptr <= next_ptr;
                    end else if (!req[gnt_id]) begin
                        state      <= ARB_IDLE;
                        gnt_valid  <= 1'b0;
                        gnt_onehot <= '0;
                    end
                end
                ARB_BUSY: begin
                    if (txn_done) begin
                        state      <= ARB_IDLE;
                        gnt_valid  <= 1'b0;
                        gnt_onehot <= '0;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state      <= ARB_IDLE;
                    gnt_valid  <= 1'b0;
                    gnt_onehot <= '0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

`ifdef BUS_ARB_PERF_EN
    always_ff @(posedge clk) begin
        // NOTE: the counter arrays are architecturally visible, so they are reset explicitly.
        if (rst) begin
            for (int i = 0; i < CPUS; i++) begin
                perf_grants[i] <= '0;
                perf_wait[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < CPUS; i++) begin
                if (state == ARB_OFFER && gnt_accept && gnt_onehot[i] && perf_grants[i] != '1)
                    perf_grants[i] <= perf_grants[i] + 32'd1;
                // Waiting means requesting without owning the bus; an un-accepted offer still waits.
                if (req[i] && !(state == ARB_BUSY && gnt_onehot[i]) && perf_wait[i] != '1)
                    perf_wait[i] <= perf_wait[i] + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bus_req_arbiter.sv
// Directed bench for bus_req_arbiter: a cycle-by-cycle vector table plus hand sequences
// for withdrawal, protocol errors, reset, and (with BUS_ARB_PERF_EN) the perf counters.
module tb_bus_req_arbiter;
    import bus_arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dREN, dWEN, ccwrite;
    logic       gnt_accept, txn_done;
    logic       gnt_valid;
    logic [1:0] gnt_onehot;
    logic [0:0] gnt_id;
    bus_req_t   gnt_type;
    logic       busy, proto_err;
`ifdef BUS_ARB_PERF_EN
    logic [31:0] perf_grants [2];
    logic [31:0] perf_wait   [2];
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bus_req_arbiter #(.CPUS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .dREN       (dREN),
        .dWEN       (dWEN),
        .ccwrite    (ccwrite),
        .gnt_accept (gnt_accept),
        .txn_done   (txn_done),
        .gnt_valid  (gnt_valid),
        .gnt_onehot (gnt_onehot),
        .gnt_id     (gnt_id),
        .gnt_type   (gnt_type),
        .busy       (busy),
        .proto_err  (proto_err)
`ifdef BUS_ARB_PERF_EN
        ,
        .perf_grants(perf_grants),
        .perf_wait  (perf_wait)
`endif
    );

    typedef struct {
        logic [1:0] dren, dwen, ccw;
        logic       acc, done;
        logic       exp_valid, exp_busy;
        logic       exp_id;
        bus_req_t   exp_type;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [1:0] dren, input logic [1:0] dwen, input logic [1:0] ccw,
                                input logic acc, input logic done, input logic v, input logic b,
                                input logic id, input bus_req_t t);
        vec_t r;
        r.dren = dren; r.dwen = dwen; r.ccw = ccw; r.acc = acc; r.done = done;
        r.exp_valid = v; r.exp_busy = b; r.exp_id = id; r.exp_type = t;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] dren, input logic [1:0] dwen, input logic [1:0] ccw,
                         input logic acc, input logic done);
        dREN = dren; dWEN = dwen; ccwrite = ccw; gnt_accept = acc; txn_done = done;
    endtask

    task automatic check_grant(input string name, input logic v, input logic b,
                               input logic id, input bus_req_t t);
        check({name, ".valid"}, 32'(gnt_valid), 32'(v));
        check({name, ".busy"},  32'(busy),      32'(b));
        if (v) begin
            check({name, ".id"},     32'(gnt_id),     32'(id));
            check({name, ".onehot"}, 32'(gnt_onehot), 32'(id ? 2'b10 : 2'b01));
            check({name, ".type"},   32'(gnt_type),   32'(t));
        end
    endtask

    initial begin
        // Round-robin: four transactions, each accepted then done 4 cycles later.
        for (int g = 0; g < 4; g++) begin
            logic id;
            id = logic'(g % 2);
            vecs.push_back(mk(2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, id, REQ_R));
            for (int k = 0; k < 3; k++)
                vecs.push_back(mk(2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, id, REQ_R));
            vecs.push_back(mk(2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, REQ_R));
            vecs.push_back(mk(2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, ~id, REQ_R));
        end
        // Classification on CPU1, frozen type, accept beating a withdrawal.
        vecs.push_back(mk(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, REQ_R));
        vecs.push_back(mk(2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, REQ_EVICT));
        vecs.push_back(mk(2'b10, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, REQ_EVICT));
        vecs.push_back(mk(2'b10, 2'b00, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, REQ_EVICT));
        vecs.push_back(mk(2'b10, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, REQ_R));
        vecs.push_back(mk(2'b10, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, REQ_RX));
        vecs.push_back(mk(2'b10, 2'b00, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, REQ_RX));
        vecs.push_back(mk(2'b00, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, REQ_R));
        vecs.push_back(mk(2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, REQ_INV));
        vecs.push_back(mk(2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, REQ_INV));
        vecs.push_back(mk(2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, REQ_R));
        vecs.push_back(mk(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, REQ_R));

        // Reset held two cycles with both CPUs requesting.
        rst = 1'b1;
        drive(2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
        tick();
        tick();
        check("reset.valid",  32'(gnt_valid),  32'd0);
        check("reset.busy",   32'(busy),       32'd0);
        check("reset.perr",   32'(proto_err),  32'd0);
        check("reset.id",     32'(gnt_id),     32'd0);
        check("reset.onehot", 32'(gnt_onehot), 32'd0);
        check("reset.type",   32'(gnt_type),   32'(REQ_R));
        rst = 1'b0;
        tick();
        check_grant("first_offer", 1'b1, 1'b0, 1'b0, REQ_R);

        foreach (vecs[i]) begin
            drive(vecs[i].dren, vecs[i].dwen, vecs[i].ccw, vecs[i].acc, vecs[i].done);
            tick();
            check_grant($sformatf("row%0d", i), vecs[i].exp_valid, vecs[i].exp_busy,
                        vecs[i].exp_id, vecs[i].exp_type);
        end

        // Withdrawal before accept keeps rr_ptr at CPU0.
        drive(2'b11, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        check_grant("wd.offer0", 1'b1, 1'b0, 1'b0, REQ_R);
        drive(2'b10, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        check_grant("wd.dropped", 1'b0, 1'b0, 1'b0, REQ_R);
        drive(2'b11, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        check_grant("wd.reoffer0", 1'b1, 1'b0, 1'b0, REQ_R);
        drive(2'b11, 2'b00, 2'b00, 1'b1, 1'b0); tick();
        check_grant("wd.busy", 1'b1, 1'b1, 1'b0, REQ_R);
        drive(2'b00, 2'b00, 2'b00, 1'b0, 1'b1); tick();
        check_grant("wd.done", 1'b0, 1'b0, 1'b0, REQ_R);
        check("wd.perr", 32'(proto_err), 32'd0);

        // txn_done in IDLE: ignored, sticky error across a clean transaction.
        drive(2'b00, 2'b00, 2'b00, 1'b0, 1'b1); tick();
        check_grant("perr.idle_done", 1'b0, 1'b0, 1'b0, REQ_R);
        check("perr.set", 32'(proto_err), 32'd1);
        drive(2'b01, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        check_grant("perr.offer", 1'b1, 1'b0, 1'b0, REQ_R);
        drive(2'b01, 2'b00, 2'b00, 1'b1, 1'b0); tick();
        drive(2'b00, 2'b00, 2'b00, 1'b0, 1'b1); tick();
        check("perr.sticky", 32'(proto_err), 32'd1);
        rst = 1'b1;
        drive(2'b00, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        check("perr.cleared", 32'(proto_err), 32'd0);
        rst = 1'b0;

        // gnt_accept in IDLE: ignored and flagged.
        drive(2'b00, 2'b00, 2'b00, 1'b1, 1'b0); tick();
        check_grant("perr.idle_acc", 1'b0, 1'b0, 1'b0, REQ_R);
        check("perr.acc_set", 32'(proto_err), 32'd1);

        // Reset in the middle of a transaction drops the grant.
        rst = 1'b1;
        drive(2'b00, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        rst = 1'b0;
        drive(2'b10, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        drive(2'b10, 2'b00, 2'b00, 1'b1, 1'b0); tick();
        check_grant("midrst.busy", 1'b1, 1'b1, 1'b1, REQ_R);
        rst = 1'b1;
        drive(2'b10, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        check_grant("midrst.dropped", 1'b0, 1'b0, 1'b0, REQ_R);
        check("midrst.perr", 32'(proto_err), 32'd0);
        rst = 1'b0;

`ifdef BUS_ARB_PERF_EN
        // CPU1 waits IDLE, OFFER and three BUSY cycles behind CPU0.
        rst = 1'b1;
        drive(2'b00, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        check("perf.rst_grants0", perf_grants[0], 32'd0);
        rst = 1'b0;
        drive(2'b11, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        drive(2'b11, 2'b00, 2'b00, 1'b1, 1'b0); tick();
        drive(2'b11, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        tick();
        drive(2'b11, 2'b00, 2'b00, 1'b0, 1'b1); tick();
        check("perf.wait1",   perf_wait[1],   32'd5);
        check("perf.wait0",   perf_wait[0],   32'd2);
        check("perf.grants0", perf_grants[0], 32'd1);
        check("perf.grants1", perf_grants[1], 32'd0);
        drive(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
